sw_job_scheduler: RTL and testbench

Host-side sequencer in front of the Smith-Waterman core's user port. It accepts job descriptors, optionally loads scoring parameters, streams query T into the core, and pulses start. It serves the core's S-chunk requests from a host S stream and captures each alignment score into a valid/ready result register. It sits between the host/DMA FIFOs and the core top, and owns every core control strobe.

---
 rtl/sw_job_scheduler_pkg.sv | 25 ++
 rtl/sw_s_feeder.sv | 35 +++
 rtl/sw_job_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_sw_job_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_job_scheduler_pkg.sv
// Shared constants and state encoding for the Smith-Waterman job scheduler.
// Core-facing widths (PE_N, VEF_BIT, MATCH_BIT) must match the core build.
// No logic; typedefs and localparams only.
package sw_job_scheduler_pkg;

   localparam int PE_N      = 64;   // PE array size, bases per S chunk
   localparam int PE_N_LOG  = 6;    // log2(PE_N)
   localparam int VEF_BIT   = 16;   // score width
   localparam int MATCH_BIT = 4;    // match/mismatch width
   localparam int TLEN_BIT  = 12;   // T word-count width
   localparam int TO_CYC    = 8;    // busy-rise watchdog window, cycles
   localparam int TW_BIT    = 18;   // one T word as consumed by the core

   typedef enum logic [2:0] {
      IDLE,
      PARAM,
      SETT,
      TSTREAM,
      TWAIT,
      START,
      CALC,
      RESULT
   } sched_state_t;

endpackage

// File: rtl/sw_s_feeder.sv
// Serves core S-chunk requests from the host S stream onto registered o_s/o_s_valid.
// Latency: o_s/o_s_valid valid 1 cycle after the request is sampled.
// Backpressure: pops only when request and chunk coincide; an unserved request shows o_s_valid=0.
module sw_s_feeder
   import sw_job_scheduler_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                i_request_s,
   input  logic                i_sc_valid,
   input  logic [2*PE_N-1:0]   i_sc,
   input  logic [PE_N_LOG:0]   i_sc_cnt,
   output logic                o_sc_ready,
   output logic [2*PE_N-1:0]   o_s,
   output logic [PE_N_LOG:0]   o_s_valid
);

   // A chunk is taken only when the core asks for one and the host has one.
   assign o_sc_ready = en & i_request_s & i_sc_valid;

   // Register the popped chunk; the base count is a one-cycle qualifier, data holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_s       <= '0;
         o_s_valid <= '0;
      end else if (o_sc_ready) begin
         o_s       <= i_sc;
         o_s_valid <= i_sc_cnt;
      end else begin
         o_s_valid <= '0;
      end
   end

endmodule

// File: rtl/sw_job_scheduler.sv
// Job sequencer in front of the SW core: params, T stream, start, result capture, S service.
// Latency: accept->o_set_t 1 cycle (2 with params); core_valid->o_res_valid 1 cycle.
// Backpressure: jobs held off while core busy or a result is unclaimed; T/S popped only when wanted.
module sw_job_scheduler
   import sw_job_scheduler_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_job_valid,
   output logic                 o_job_ready,
   input  logic [TLEN_BIT-1:0]  i_job_tlen,
   input  logic                 i_job_param,
   input  logic [MATCH_BIT-1:0] i_match,
   input  logic [MATCH_BIT-1:0] i_mismatch,
   input  logic [7:0]           i_alpha,
   input  logic [7:0]           i_beta,
   input  logic                 i_tw_valid,
   output logic                 o_tw_ready,
   input  logic [TW_BIT-1:0]    i_tw,
   input  logic                 i_sc_valid,
   output logic                 o_sc_ready,
   input  logic [2*PE_N-1:0]    i_sc,
   input  logic [PE_N_LOG:0]    i_sc_cnt,
   output logic                 o_set_t,
   output logic                 o_start_cal,
   output logic [TW_BIT-1:0]    o_t,
   output logic [MATCH_BIT-1:0] o_match,
   output logic [MATCH_BIT-1:0] o_mismatch,
   output logic [7:0]           o_alpha,
   output logic [7:0]           o_beta,
   output logic                 o_param_valid,
   input  logic                 i_request_s,
   output logic [2*PE_N-1:0]    o_s,
   output logic [PE_N_LOG:0]    o_s_valid,
   input  logic                 i_core_busy,
   input  logic [VEF_BIT-1:0]   i_core_result,
   input  logic                 i_core_valid,
   output logic [VEF_BIT-1:0]   o_res,
   output logic                 o_res_valid,
   input  logic                 i_res_ready,
   output logic                 o_err
);

   localparam int                WD_W    = $clog2(TO_CYC + 1);
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TO_CYC - 1);

   sched_state_t          state, state_nxt;
   logic                  live;       // low through reset and its first cycle out
   logic [TLEN_BIT-1:0]   tlen_q;
   logic [TLEN_BIT-1:0]   cnt;
   logic                  rose;       // busy seen high since the last strobe
   logic [WD_W-1:0]       wd;         // cycles elapsed since the last strobe, saturating
   logic                  job_acc;
   logic                  tw_acc;
   logic                  capture;
   logic                  wd_fire;

   // Next-state and strobe decode; all strobes are Moore outputs of the state register.
   always_comb begin
      state_nxt     = state;
      o_job_ready   = 1'b0;
      o_param_valid = 1'b0;
      o_set_t       = 1'b0;
      o_tw_ready    = 1'b0;
      o_start_cal   = 1'b0;
      job_acc       = 1'b0;
      tw_acc        = 1'b0;
      capture       = 1'b0;
      wd_fire       = (state == TWAIT || state == CALC) && !rose && !i_core_busy && (wd == WD_LAST);
      case (state)
         IDLE: begin
            o_job_ready = live && !i_core_busy && !o_res_valid;
            if (i_job_valid && o_job_ready) begin
               job_acc = 1'b1;
               if (i_job_param)              state_nxt = PARAM;
               else if (i_job_tlen != '0)    state_nxt = SETT;
               else                          state_nxt = START;
            end
         end
         PARAM: begin
            o_param_valid = 1'b1;
            state_nxt     = (tlen_q != '0) ? SETT : START;
         end
         SETT: begin
            o_set_t   = 1'b1;
            state_nxt = TSTREAM;
         end
         TSTREAM: begin
            o_tw_ready = (cnt != '0);
            if (cnt == '0) begin
               state_nxt = TWAIT;
            end else if (i_tw_valid) begin
               tw_acc = 1'b1;
               if (cnt == TLEN_BIT'(1)) state_nxt = TWAIT;
            end
         end
         TWAIT: begin
            if (wd_fire)                    state_nxt = IDLE;
            else if (rose && !i_core_busy)  state_nxt = START;
         end
         START: begin
            o_start_cal = 1'b1;
            state_nxt   = CALC;
         end
         CALC: begin
            if (wd_fire) begin
               state_nxt = IDLE;
            end else if (i_core_valid && (rose || i_core_busy)) begin
               capture   = 1'b1;
               state_nxt = RESULT;
            end
         end
         RESULT: begin
            if (i_res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Latch the job descriptor; parameters only change when the job carries new ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         live       <= 1'b0;
         tlen_q     <= '0;
         o_match    <= '0;
         o_mismatch <= '0;
         o_alpha    <= '0;
         o_beta     <= '0;
      end else begin
         live <= 1'b1;
         if (job_acc) begin
            tlen_q <= i_job_tlen;
            if (i_job_param) begin
               o_match    <= i_match;
               o_mismatch <= i_mismatch;
               o_alpha    <= i_alpha;
               o_beta     <= i_beta;
            end
         end
      end
   end

   // T word counter and the registered T word toward the core; o_t holds across stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         o_t <= '0;
      end else if (state == SETT) begin
         cnt <= tlen_q;
      end else if (tw_acc) begin
         cnt <= cnt - 1'b1;
         o_t <= i_tw;
      end
   end

   // Busy-rise tracking; the window restarts on each strobe so a rise during T streaming counts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rose <= 1'b0;
         wd   <= '0;
      end else if (state == SETT || state == START) begin
         rose <= 1'b0;
         wd   <= '0;
      end else begin
         if (i_core_busy)   rose <= 1'b1;
         if (wd != WD_LAST) wd   <= wd + 1'b1;
      end
   end

   // Result register with valid/ready hold, and the sticky watchdog error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_res       <= '0;
         o_res_valid <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         if (wd_fire) o_err <= 1'b1;
         if (capture) begin
            o_res       <= i_core_result;
            o_res_valid <= 1'b1;
         end else if (state == RESULT && i_res_ready) begin
            o_res       <= '0;
            o_res_valid <= 1'b0;
         end
      end
   end

   sw_s_feeder u_s_feeder (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (live),
      .i_request_s (i_request_s),
      .i_sc_valid  (i_sc_valid),
      .i_sc        (i_sc),
      .i_sc_cnt    (i_sc_cnt),
      .o_sc_ready  (o_sc_ready),
      .o_s         (o_s),
      .o_s_valid   (o_s_valid)
   );

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Directed bench for sw_job_scheduler: param/T/start sequencing, result hold, S service, watchdog, reset.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled in the same window.
// The core is modelled by hand-driven busy/valid/result values in the step sequence.
module tb_sw_job_scheduler;
   import sw_job_scheduler_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 i_job_valid;
   logic                 o_job_ready;
   logic [TLEN_BIT-1:0]  i_job_tlen;
   logic                 i_job_param;
   logic [MATCH_BIT-1:0] i_match, i_mismatch;
   logic [7:0]           i_alpha, i_beta;
   logic                 i_tw_valid;
   logic                 o_tw_ready;
   logic [TW_BIT-1:0]    i_tw;
   logic                 i_sc_valid;
   logic                 o_sc_ready;
   logic [2*PE_N-1:0]    i_sc;
   logic [PE_N_LOG:0]    i_sc_cnt;
   logic                 o_set_t, o_start_cal;
   logic [TW_BIT-1:0]    o_t;
   logic [MATCH_BIT-1:0] o_match, o_mismatch;
   logic [7:0]           o_alpha, o_beta;
   logic                 o_param_valid;
   logic                 i_request_s;
   logic [2*PE_N-1:0]    o_s;
   logic [PE_N_LOG:0]    o_s_valid;
   logic                 i_core_busy;
   logic [VEF_BIT-1:0]   i_core_result;
   logic                 i_core_valid;
   logic [VEF_BIT-1:0]   o_res;
   logic                 o_res_valid;
   logic                 i_res_ready;
   logic                 o_err;

   int n_checks = 0;
   int n_fail   = 0;
   int tw_pops  = 0;
   int sc_pops  = 0;
   int n_start  = 0;
   int n_sett   = 0;

   logic [2*PE_N-1:0] sc_a;
   logic [2*PE_N-1:0] sc_b;

   always #5 clk = ~clk;

   sw_job_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_job_valid   (i_job_valid),
      .o_job_ready   (o_job_ready),
      .i_job_tlen    (i_job_tlen),
      .i_job_param   (i_job_param),
      .i_match       (i_match),
      .i_mismatch    (i_mismatch),
      .i_alpha       (i_alpha),
      .i_beta        (i_beta),
      .i_tw_valid    (i_tw_valid),
      .o_tw_ready    (o_tw_ready),
      .i_tw          (i_tw),
      .i_sc_valid    (i_sc_valid),
      .o_sc_ready    (o_sc_ready),
      .i_sc          (i_sc),
      .i_sc_cnt      (i_sc_cnt),
      .o_set_t       (o_set_t),
      .o_start_cal   (o_start_cal),
      .o_t           (o_t),
      .o_match       (o_match),
      .o_mismatch    (o_mismatch),
      .o_alpha       (o_alpha),
      .o_beta        (o_beta),
      .o_param_valid (o_param_valid),
      .i_request_s   (i_request_s),
      .o_s           (o_s),
      .o_s_valid     (o_s_valid),
      .i_core_busy   (i_core_busy),
      .i_core_result (i_core_result),
      .i_core_valid  (i_core_valid),
      .o_res         (o_res),
      .o_res_valid   (o_res_valid),
      .i_res_ready   (i_res_ready),
      .o_err         (o_err)
   );

   // Handshake and strobe counters observed at the active edge.
   always @(posedge clk) begin
      if (o_tw_ready && i_tw_valid) tw_pops <= tw_pops + 1;
      if (o_sc_ready && i_sc_valid) sc_pops <= sc_pops + 1;
      if (o_start_cal)              n_start <= n_start + 1;
      if (o_set_t)                  n_sett  <= n_sett + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      sc_a = {32{4'hA}};
      sc_b = {16{8'h3C}};
      rst_n = 1'b0; i_job_valid = 1'b0; i_job_tlen = '0; i_job_param = 1'b0;
      i_match = '0; i_mismatch = '0; i_alpha = '0; i_beta = '0;
      i_tw_valid = 1'b0; i_tw = '0; i_sc_valid = 1'b1; i_sc = '0; i_sc_cnt = '0;
      i_request_s = 1'b1; i_core_busy = 1'b0; i_core_result = '0; i_core_valid = 1'b0; i_res_ready = 1'b0;

      // ---- reset state
      cyc(); cyc();
      n_checks++; assert (o_job_ready === 1'b0) else begin n_fail++; $error("FAIL rst_job_ready obs=%0h exp=0", o_job_ready); end
      n_checks++; assert (o_sc_ready === 1'b0) else begin n_fail++; $error("FAIL rst_sc_ready obs=%0h exp=0", o_sc_ready); end
      n_checks++; assert (o_s_valid === 7'd0 && o_s === '0) else begin n_fail++; $error("FAIL rst_s obs=%0h/%0h exp=0/0", o_s_valid, o_s); end
      n_checks++; assert ({o_set_t, o_start_cal, o_param_valid, o_tw_ready} === 4'b0000) else begin n_fail++; $error("FAIL rst_strobes obs=%0h exp=0", {o_set_t, o_start_cal, o_param_valid, o_tw_ready}); end
      n_checks++; assert ({o_err, o_res_valid, o_res, o_t} === '0) else begin n_fail++; $error("FAIL rst_regs obs=%0h exp=0", {o_err, o_res_valid, o_res, o_t}); end
      i_request_s = 1'b0; i_sc_valid = 1'b0; rst_n = 1'b1; #1;
      n_checks++; assert (o_job_ready === 1'b0) else begin n_fail++; $error("FAIL ready_at_release obs=%0h exp=0", o_job_ready); end
      cyc();
      n_checks++; assert (o_job_ready === 1'b1) else begin n_fail++; $error("FAIL first_job_ready obs=%0h exp=1", o_job_ready); end

      // ---- job 1: tlen=3 with parameters
      i_job_valid = 1'b1; i_job_tlen = 12'd3; i_job_param = 1'b1;
      i_match = 4'd6; i_mismatch = 4'd3; i_alpha = 8'd2; i_beta = 8'd1;
      cyc(); // PARAM
      i_job_valid = 1'b0; i_job_param = 1'b0; i_match = '0; i_mismatch = '0; i_alpha = '0; i_beta = '0; #1;
      n_checks++; assert (o_param_valid === 1'b1 && o_set_t === 1'b0) else begin n_fail++; $error("FAIL param_pulse obs=%0h/%0h exp=1/0", o_param_valid, o_set_t); end
      n_checks++; assert ({o_match, o_mismatch, o_alpha, o_beta} === {4'd6, 4'd3, 8'd2, 8'd1}) else begin n_fail++; $error("FAIL param_vals obs=%0h exp=630201", {o_match, o_mismatch, o_alpha, o_beta}); end
      cyc(); // SETT
      n_checks++; assert (o_set_t === 1'b1 && o_param_valid === 1'b0) else begin n_fail++; $error("FAIL set_t_pulse obs=%0h/%0h exp=1/0", o_set_t, o_param_valid); end
      cyc(); // TSTREAM, 3 words left
      i_tw_valid = 1'b1; i_tw = 18'h2_0001; #1;
      n_checks++; assert (o_tw_ready === 1'b1) else begin n_fail++; $error("FAIL tw_ready obs=%0h exp=1", o_tw_ready); end
      cyc();
      n_checks++; assert (o_t === 18'h2_0001) else begin n_fail++; $error("FAIL t_word1 obs=%0h exp=20001", o_t); end
      i_core_busy = 1'b1; i_tw_valid = 1'b0;
      cyc(); // stall cycle
      n_checks++; assert (o_t === 18'h2_0001) else begin n_fail++; $error("FAIL t_hold obs=%0h exp=20001", o_t); end
      i_tw_valid = 1'b1; i_tw = 18'h1_5555;
      cyc();
      n_checks++; assert (o_t === 18'h1_5555) else begin n_fail++; $error("FAIL t_word2 obs=%0h exp=15555", o_t); end
      i_core_busy = 1'b0; i_tw = 18'h3_FFFE;
      cyc(); // TWAIT
      i_tw = 18'h0_0ABC; #1;
      n_checks++; assert (o_t === 18'h3_FFFE) else begin n_fail++; $error("FAIL t_word3 obs=%0h exp=3fffe", o_t); end
      n_checks++; assert (o_tw_ready === 1'b0 && o_start_cal === 1'b0) else begin n_fail++; $error("FAIL twait obs=%0h/%0h exp=0/0", o_tw_ready, o_start_cal); end
      cyc(); // START
      i_tw_valid = 1'b0;
      n_checks++; assert (o_start_cal === 1'b1) else begin n_fail++; $error("FAIL start_cal1 obs=%0h exp=1", o_start_cal); end
      n_checks++; assert (tw_pops === 3) else begin n_fail++; $error("FAIL tw_pop_count obs=%0d exp=3", tw_pops); end
      cyc(); // CALC
      n_checks++; assert (o_start_cal === 1'b0) else begin n_fail++; $error("FAIL start_cal_one_cycle obs=%0h exp=0", o_start_cal); end
      cyc();
      i_core_busy = 1'b1;
      cyc();
      i_core_valid = 1'b1; i_core_result = 16'h002A;
      i_request_s = 1'b1; i_sc_valid = 1'b1; i_sc_cnt = 7'd5; i_sc = sc_a;
      i_job_valid = 1'b1; i_job_tlen = 12'd0; i_job_param = 1'b0; #1;
      n_checks++; assert (o_sc_ready === 1'b1 && o_job_ready === 1'b0) else begin n_fail++; $error("FAIL calc_sc_job obs=%0h/%0h exp=1/0", o_sc_ready, o_job_ready); end
      cyc(); // RESULT; S chunk served in parallel
      i_core_valid = 1'b0; i_core_busy = 1'b0; i_request_s = 1'b0; i_sc_valid = 1'b0;
      n_checks++; assert (o_s_valid === 7'd5 && o_s === sc_a) else begin n_fail++; $error("FAIL s_with_result obs=%0h exp=5", o_s_valid); end

      // ---- result held 5 cycles, next job blocked
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++; assert (o_res_valid === 1'b1 && o_res === 16'h002A && o_job_ready === 1'b0) else begin n_fail++; $error("FAIL res_hold%0d obs=%0h/%0h/%0h exp=1/2a/0", k, o_res_valid, o_res, o_job_ready); end
         cyc();
      end
      i_res_ready = 1'b1; #1;
      n_checks++; assert (o_res_valid === 1'b1 && o_job_ready === 1'b0) else begin n_fail++; $error("FAIL res_at_handshake obs=%0h/%0h exp=1/0", o_res_valid, o_job_ready); end
      cyc(); // IDLE
      n_checks++; assert (o_res_valid === 1'b0 && o_res === 16'h0000) else begin n_fail++; $error("FAIL res_cleared obs=%0h/%0h exp=0/0", o_res_valid, o_res); end
      n_checks++; assert (o_job_ready === 1'b1) else begin n_fail++; $error("FAIL ready_after_result obs=%0h exp=1", o_job_ready); end

      // ---- job 2: tlen=0 reuses T, core never goes busy
      cyc(); // START, one cycle after acceptance
      i_job_valid = 1'b0; i_res_ready = 1'b0;
      n_checks++; assert (o_start_cal === 1'b1 && o_set_t === 1'b0) else begin n_fail++; $error("FAIL tlen0_start obs=%0h/%0h exp=1/0", o_start_cal, o_set_t); end
      for (int k = 1; k <= TO_CYC; k++) begin
         cyc();
         n_checks++; assert (o_err === 1'b0) else begin n_fail++; $error("FAIL wd_early%0d obs=%0h exp=0", k, o_err); end
      end
      cyc(); // strobe + TO_CYC + 1
      n_checks++; assert (o_err === 1'b1) else begin n_fail++; $error("FAIL wd_err obs=%0h exp=1", o_err); end
      n_checks++; assert (o_job_ready === 1'b1 && o_res_valid === 1'b0) else begin n_fail++; $error("FAIL wd_idle obs=%0h/%0h exp=1/0", o_job_ready, o_res_valid); end
      n_checks++; assert (n_start === 2 && n_sett === 1 && tw_pops === 3) else begin n_fail++; $error("FAIL strobe_counts obs=%0d/%0d/%0d exp=2/1/3", n_start, n_sett, tw_pops); end

      // ---- S request against an empty stream, then a 17-base chunk
      i_request_s = 1'b1; i_sc_valid = 1'b0; #1;
      n_checks++; assert (o_sc_ready === 1'b0) else begin n_fail++; $error("FAIL sc_no_chunk obs=%0h exp=0", o_sc_ready); end
      cyc();
      n_checks++; assert (o_s_valid === 7'd0) else begin n_fail++; $error("FAIL s_empty1 obs=%0h exp=0", o_s_valid); end
      cyc();
      n_checks++; assert (o_s_valid === 7'd0) else begin n_fail++; $error("FAIL s_empty2 obs=%0h exp=0", o_s_valid); end
      cyc();
      n_checks++; assert (o_s_valid === 7'd0) else begin n_fail++; $error("FAIL s_empty3 obs=%0h exp=0", o_s_valid); end
      i_sc_valid = 1'b1; i_sc_cnt = 7'd17; i_sc = sc_b; #1;
      n_checks++; assert (o_sc_ready === 1'b1) else begin n_fail++; $error("FAIL sc_pop obs=%0h exp=1", o_sc_ready); end
      cyc();
      n_checks++; assert (o_s_valid === 7'd17 && o_s === sc_b) else begin n_fail++; $error("FAIL s_chunk17 obs=%0h exp=11", o_s_valid); end
      i_request_s = 1'b0; #1;
      n_checks++; assert (o_sc_ready === 1'b0) else begin n_fail++; $error("FAIL sc_no_request obs=%0h exp=0", o_sc_ready); end
      cyc();
      i_sc_valid = 1'b0;
      n_checks++; assert (o_s_valid === 7'd0 && sc_pops === 2) else begin n_fail++; $error("FAIL s_one_cycle obs=%0h/%0d exp=0/2", o_s_valid, sc_pops); end
      n_checks++; assert (o_err === 1'b1) else begin n_fail++; $error("FAIL err_sticky obs=%0h exp=1", o_err); end

      // ---- reset mid-TSTREAM at word 2 of 5
      i_job_valid = 1'b1; i_job_tlen = 12'd5; i_job_param = 1'b0;
      cyc(); // SETT
      i_job_valid = 1'b0;
      n_checks++; assert (o_set_t === 1'b1) else begin n_fail++; $error("FAIL job3_set_t obs=%0h exp=1", o_set_t); end
      cyc(); // TSTREAM
      i_tw_valid = 1'b1; i_tw = 18'h0_0101;
      cyc();
      n_checks++; assert (o_t === 18'h0_0101) else begin n_fail++; $error("FAIL job3_word1 obs=%0h exp=101", o_t); end
      i_tw = 18'h0_0202; rst_n = 1'b0;
      cyc();
      n_checks++; assert ({o_t, o_err, o_job_ready, o_tw_ready, o_set_t, o_start_cal, o_param_valid, o_res_valid} === '0) else begin n_fail++; $error("FAIL midjob_reset obs=%0h exp=0", {o_t, o_err, o_job_ready, o_tw_ready, o_set_t, o_start_cal, o_param_valid, o_res_valid}); end
      n_checks++; assert (o_s_valid === 7'd0 && o_res === 16'h0000) else begin n_fail++; $error("FAIL midjob_reset_s obs=%0h/%0h exp=0/0", o_s_valid, o_res); end
      rst_n = 1'b1; i_tw_valid = 1'b0;
      cyc();
      n_checks++; assert (o_job_ready === 1'b1) else begin n_fail++; $error("FAIL ready_after_reset obs=%0h exp=1", o_job_ready); end

      // ---- normal job after reset: tlen=0, result 0x1234
      i_job_valid = 1'b1; i_job_tlen = 12'd0;
      cyc(); // START
      i_job_valid = 1'b0;
      n_checks++; assert (o_start_cal === 1'b1 && o_tw_ready === 1'b0) else begin n_fail++; $error("FAIL job4_start obs=%0h/%0h exp=1/0", o_start_cal, o_tw_ready); end
      cyc();
      cyc();
      i_core_busy = 1'b1;
      cyc();
      i_core_valid = 1'b1; i_core_result = 16'h1234; i_res_ready = 1'b1;
      cyc(); // RESULT
      i_core_valid = 1'b0; i_core_busy = 1'b0;
      n_checks++; assert (o_res_valid === 1'b1 && o_res === 16'h1234 && o_err === 1'b0) else begin n_fail++; $error("FAIL job4_result obs=%0h/%0h/%0h exp=1/1234/0", o_res_valid, o_res, o_err); end
      cyc();
      i_res_ready = 1'b0;
      n_checks++; assert (o_res_valid === 1'b0 && o_job_ready === 1'b1) else begin n_fail++; $error("FAIL job4_done obs=%0h/%0h exp=0/1", o_res_valid, o_job_ready); end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
